// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file write-port logic.
//   REG_AW   : register address width (32 architectural registers)
//   DATA_W   : register data width
//   ZERO_REG : hard-wired zero register; writes to it are discarded
//   wr_req_t : one register-file write (destination + data), used for
//              queued multi-cycle results and the FIFO head
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_wport_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// mc_result_fifo
// Small synchronous FIFO holding multi-cycle results that lost write-port
// arbitration to the pipeline writeback.
//   CLK       : clock, all updates on posedge
//   RST       : synchronous active-high reset, empties the FIFO
//   push      : enqueue push_data this cycle
//   push_data : write request to enqueue
//   pop       : remove the head entry this cycle
//   full      : DEPTH entries held
//   empty     : no entries held
//   head      : oldest entry (valid when !empty)
// ---------------------------------------------------------------------------
module mc_result_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    CLK,
    input  logic    RST,
    input  logic    push,
    input  wr_req_t push_data,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wr_req_t head
);

    localparam int AW = $clog2(DEPTH);

    wr_req_t       mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit: equal indices with equal wrap bits
    // mean empty, equal indices with different wrap bits mean full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A push while full is only safe when the head leaves in the same cycle,
    // because the freed slot is the one being written.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Pointer bookkeeping; reset drops everything that was queued.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers decide which entries are live.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wport_arbiter
// Shares the register file's single write port between pipeline writeback
// (highest priority) and multi-cycle unit results. Losing results wait in a
// small FIFO; a scoreboard flags registers with outstanding multi-cycle
// results; a starvation counter requests a writeback hold when the FIFO head
// has waited too long.
//   CLK, RST            : clock, synchronous active-high reset
//   WB_WE/WB_W/WB_Din   : pipeline writeback request, destination, data
//   MC_Issue/MC_IssueW  : multi-cycle op issued and its destination
//   MC_Valid/MC_W/MC_Din: multi-cycle result handshake, destination, data
//   MC_Ready            : result accepted when MC_Valid && MC_Ready
//   Q_R1/Q_R2           : source registers being decoded
//   Hazard              : either decoded source has an outstanding result
//   WB_Hold             : pipeline must not write back next cycle
//   RF_WE/RF_W/RF_Din   : register file write port
//   Busy                : scoreboard (bit 0 always 0)
// ---------------------------------------------------------------------------
module regfile_wport_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WB_WE,
    input  logic [REG_AW-1:0] WB_W,
    input  logic [DATA_W-1:0] WB_Din,
    input  logic              MC_Issue,
    input  logic [REG_AW-1:0] MC_IssueW,
    input  logic              MC_Valid,
    input  logic [REG_AW-1:0] MC_W,
    input  logic [DATA_W-1:0] MC_Din,
    output logic              MC_Ready,
    input  logic [REG_AW-1:0] Q_R1,
    input  logic [REG_AW-1:0] Q_R2,
    output logic              Hazard,
    output logic              WB_Hold,
    output logic              RF_WE,
    output logic [REG_AW-1:0] RF_W,
    output logic [DATA_W-1:0] RF_Din,
    output logic [31:0]       Busy
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic          wb_req;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          fifo_push;
    logic          bypass;
    wr_req_t       fifo_head;
    wr_req_t       mc_req;
    logic [CW-1:0] starve_cnt;
    logic [31:0]   busy_q;
    logic [31:0]   busy_d;

    // A writeback to r0 is a no-op and must not take the port away from a
    // waiting multi-cycle result.
    assign wb_req = WB_WE && (WB_W != ZERO_REG);

    assign MC_Ready = !fifo_full && !RST;

    // Grant decisions: writeback first, then the FIFO head, then a result
    // arriving while the FIFO is empty goes straight to the register file.
    assign fifo_pop = !RST && !wb_req && !fifo_empty;
    assign bypass   = !RST && !wb_req && fifo_empty && MC_Valid && (MC_W != ZERO_REG);

    // Results for r0 are accepted but silently dropped.
    assign fifo_push = MC_Valid && MC_Ready && !bypass && (MC_W != ZERO_REG);

    assign mc_req = '{addr: MC_W, data: MC_Din};

    mc_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (fifo_push),
        .push_data (mc_req),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Write-port mux. Everything here is combinational so the register file
    // can sample it at the negedge of the same cycle.
    always_comb begin
        RF_WE  = 1'b0;
        RF_W   = ZERO_REG;
        RF_Din = '0;
        if (wb_req && !RST) begin
            RF_WE  = 1'b1;
            RF_W   = WB_W;
            RF_Din = WB_Din;
        end else if (fifo_pop) begin
            RF_WE  = 1'b1;
            RF_W   = fifo_head.addr;
            RF_Din = fifo_head.data;
        end else if (bypass) begin
            RF_WE  = 1'b1;
            RF_W   = MC_W;
            RF_Din = MC_Din;
        end
    end

    // Scoreboard next state: a result reaching the register file clears its
    // bit, then a new issue sets its bit so an issue to the same register in
    // the same cycle keeps it busy. Writebacks never touch the scoreboard.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop) begin
            busy_d[fifo_head.addr] = 1'b0;
        end else if (bypass) begin
            busy_d[MC_W] = 1'b0;
        end
        if (MC_Issue && (MC_IssueW != ZERO_REG)) begin
            busy_d[MC_IssueW] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register; new bits become visible to Hazard next cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign Busy   = busy_q;
    assign Hazard = !RST && (busy_q[Q_R1] || busy_q[Q_R2]);

    // Starvation counter: counts cycles the FIFO head sits waiting behind
    // writeback, saturating at the limit so a pipeline that ignores WB_Hold
    // does not wrap it back to zero.
    always_ff @(posedge CLK) begin
        if (RST || fifo_empty || fifo_pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt < CW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign WB_Hold = !RST && (starve_cnt >= CW'(STARVE_LIMIT));

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wport_arbiter
// Self-checking bench for regfile_wport_arbiter. A behavioural model (queue
// of pending results, busy bit array, wait counter) predicts every output
// each cycle; directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_regfile_wport_arbiter;
    import regfile_pkg::*;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WB_WE;
    logic [4:0]  WB_W;
    logic [31:0] WB_Din;
    logic        MC_Issue;
    logic [4:0]  MC_IssueW;
    logic        MC_Valid;
    logic [4:0]  MC_W;
    logic [31:0] MC_Din;
    logic        MC_Ready;
    logic [4:0]  Q_R1;
    logic [4:0]  Q_R2;
    logic        Hazard;
    logic        WB_Hold;
    logic        RF_WE;
    logic [4:0]  RF_W;
    logic [31:0] RF_Din;
    logic [31:0] Busy;

    int vectors    = 0;
    int miscompares = 0;

    wr_req_t     mq[$];
    logic [31:0] mbusy = '0;
    int          mwait = 0;

    regfile_wport_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .WB_WE     (WB_WE),
        .WB_W      (WB_W),
        .WB_Din    (WB_Din),
        .MC_Issue  (MC_Issue),
        .MC_IssueW (MC_IssueW),
        .MC_Valid  (MC_Valid),
        .MC_W      (MC_W),
        .MC_Din    (MC_Din),
        .MC_Ready  (MC_Ready),
        .Q_R1      (Q_R1),
        .Q_R2      (Q_R2),
        .Hazard    (Hazard),
        .WB_Hold   (WB_Hold),
        .RF_WE     (RF_WE),
        .RF_W      (RF_W),
        .RF_Din    (RF_Din),
        .Busy      (Busy)
    );

    // Free-running clock, period 10.
    always #5 CLK = ~CLK;

    // One comparison: counts it and reports any difference.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Predict this cycle's outputs from the model state and current inputs.
    task automatic checkOutput();
        logic        wbreq;
        logic        e_we;
        logic [4:0]  e_w;
        logic [31:0] e_d;
        wbreq = WB_WE && (WB_W != 5'd0);
        e_we  = 1'b0;
        e_w   = 5'd0;
        e_d   = '0;
        if (!RST) begin
            if (wbreq) begin
                e_we = 1'b1; e_w = WB_W; e_d = WB_Din;
            end else if (mq.size() > 0) begin
                e_we = 1'b1; e_w = mq[0].addr; e_d = mq[0].data;
            end else if (MC_Valid && MC_W != 5'd0) begin
                e_we = 1'b1; e_w = MC_W; e_d = MC_Din;
            end
        end
        chk("rf_we", 32'(RF_WE), 32'(e_we));
        if (e_we) begin
            chk("rf_w", 32'(RF_W), 32'(e_w));
            chk("rf_din", RF_Din, e_d);
        end
        chk("mc_ready", 32'(MC_Ready), 32'(!RST && mq.size() < DEPTH));
        chk("wb_hold", 32'(WB_Hold), 32'(!RST && mwait >= STARVE_LIMIT));
        chk("hazard", 32'(Hazard), 32'(!RST && (mbusy[Q_R1] || mbusy[Q_R2])));
        chk("busy", Busy, mbusy);
    endtask

    // Advance the model by one clock using the current inputs.
    task automatic modelUpdate();
        logic wbreq;
        logic popped;
        logic bypassed;
        logic accepted;
        if (RST) begin
            mq.delete();
            mbusy = '0;
            mwait = 0;
            return;
        end
        wbreq    = WB_WE && (WB_W != 5'd0);
        popped   = !wbreq && mq.size() > 0;
        bypassed = !wbreq && mq.size() == 0 && MC_Valid && MC_W != 5'd0;
        accepted = MC_Valid && mq.size() < DEPTH;
        if (mq.size() == 0 || popped) begin
            mwait = 0;
        end else if (mwait < STARVE_LIMIT) begin
            mwait++;
        end
        if (popped) begin
            mbusy[mq[0].addr] = 1'b0;
            void'(mq.pop_front());
        end
        if (bypassed) begin
            mbusy[MC_W] = 1'b0;
        end
        if (accepted && !bypassed && MC_W != 5'd0) begin
            mq.push_back('{addr: MC_W, data: MC_Din});
        end
        if (MC_Issue && MC_IssueW != 5'd0) begin
            mbusy[MC_IssueW] = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, check mid-cycle, then step to the next cycle.
    task automatic applyStimulus(input logic rst, input logic wbwe, input logic [4:0] wbw,
                                 input logic [31:0] wbdin, input logic issue,
                                 input logic [4:0] issuew, input logic valid,
                                 input logic [4:0] mcw, input logic [31:0] mcdin,
                                 input logic [4:0] r1, input logic [4:0] r2);
        RST = rst; WB_WE = wbwe; WB_W = wbw; WB_Din = wbdin;
        MC_Issue = issue; MC_IssueW = issuew;
        MC_Valid = valid; MC_W = mcw; MC_Din = mcdin;
        Q_R1 = r1; Q_R2 = r2;
        #2;
        checkOutput();
        modelUpdate();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [4:0] rnd_reg();
        return 5'($urandom_range(1, 31));
    endfunction

    initial begin
        RST = 1'b1; WB_WE = 0; WB_W = 0; WB_Din = 0; MC_Issue = 0; MC_IssueW = 0;
        MC_Valid = 0; MC_W = 0; MC_Din = 0; Q_R1 = 0; Q_R2 = 0;
        @(posedge CLK);
        #1;

        $display("[TB] reset and idle");
        applyStimulus(1, 1, 5'd7, 32'h11, 1, 5'd4, 1, 5'd6, 32'h22, 5'd4, 5'd6);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("busy_after_reset", Busy, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] bypass to idle port");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] queued result under continuous writeback");
        applyStimulus(0, 0, 0, 0, 1, 5'd8, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, rnd_reg(), $urandom, 0, 0, 1, 5'd8, 32'h1234, 5'd8, 5'd0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1, rnd_reg(), $urandom, 0, 0, 0, 0, 0, 5'd8, rnd_reg());
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd8, 0);
        chk("busy8_cleared", 32'(Busy[8]), 32'h0);

        $display("[TB] fill the FIFO");
        applyStimulus(0, 1, 5'd1, $urandom, 1, 5'd10, 1, 5'd10, 32'hA0A0, 0, 0);
        applyStimulus(0, 1, 5'd2, $urandom, 1, 5'd11, 1, 5'd11, 32'hB1B1, 5'd10, 5'd11);
        applyStimulus(0, 1, 5'd3, $urandom, 0, 0, 1, 5'd12, 32'hC2C2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd12, 32'hC2C2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd12, 32'hC2C2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd12, 5'd10);

        $display("[TB] pop and reissue of the same register");
        applyStimulus(0, 0, 0, 0, 1, 5'd9, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 5'd4, $urandom, 0, 0, 1, 5'd9, 32'h9999, 5'd9, 0);
        applyStimulus(0, 0, 0, 0, 1, 5'd9, 0, 0, 0, 0, 0);
        chk("busy9_kept", 32'(Busy[9]), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9);

        $display("[TB] writeback to r0 does not block the FIFO");
        applyStimulus(0, 1, 5'd6, $urandom, 1, 5'd3, 1, 5'd3, 32'h3333, 0, 0);
        applyStimulus(0, 1, 5'd0, 32'hFFFF, 0, 0, 0, 0, 0, 5'd3, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'h5555, 0, 0);

        $display("[TB] reset mid-queue");
        applyStimulus(0, 1, 5'd7, $urandom, 1, 5'd4, 1, 5'd4, 32'h4444, 0, 0);
        applyStimulus(0, 1, 5'd7, $urandom, 1, 5'd5, 1, 5'd5, 32'h5050, 5'd4, 5'd5);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd4, 5'd5);
        chk("busy_after_midreset", Busy, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd4, 5'd5);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 65,
                          5'($urandom_range(0, 31)), $urandom,
                          $urandom_range(0, 99) < 30, 5'($urandom_range(0, 31)),
                          $urandom_range(0, 99) < 40, 5'($urandom_range(0, 31)), $urandom,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
